bcd2bin_seq: RTL and testbench



---
 rtl/bcd2bin_seq.sv | 110 +++++++++++
 tb/tb_bcd2bin_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// Sequential three-digit BCD to 8-bit binary converter (reverse double-dabble).
// One shift/correct step per clock; ten steps per conversion, then a one-cycle done strobe.
module bcd2bin_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] centenas,
  input  logic [3:0] dezenas,
  input  logic [3:0] unidades,
  output logic [7:0] binary,
  output logic       busy,
  output logic       done,
  output logic       erro_digito,
  output logic       estouro
);

  // Handshake: start is sampled only on an edge where busy=0; the result on
  // binary/erro_digito/estouro is valid from the edge that raises done and is
  // held until the next done. There is no backpressure and no queueing.

  typedef enum logic {
    OCIOSO   = 1'b0,
    CONVERTE = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [21:0] shift_q;
  logic [21:0] shifted;
  logic [21:0] shift_step;
  logic [3:0]  count_q;
  logic        err_q;
  logic        load;
  logic        last_step;
  logic [9:0]  result;

  function automatic logic [3:0] adjust(input logic [3:0] nib);
    return (nib >= 4'd8) ? (nib - 4'd3) : nib;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= OCIOSO;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      OCIOSO:   if (start) state_next = CONVERTE;
      CONVERTE: if (count_q == 4'd9) state_next = OCIOSO;
      default:  state_next = OCIOSO;
    endcase
  end

  // FSM outputs and control strobes
  always_comb begin
    busy      = (state == CONVERTE);
    load      = (state == OCIOSO) && start;
    last_step = (state == CONVERTE) && (count_q == 4'd9);
  end

  // One reverse double-dabble step: shift right, then pull each BCD nibble back below 8
  always_comb begin
    shifted    = {1'b0, shift_q[21:1]};
    shift_step = {adjust(shifted[21:18]), adjust(shifted[17:14]),
                  adjust(shifted[13:10]), shifted[9:0]};
    result     = shift_step[9:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q     <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      binary      <= '0;
      done        <= 1'b0;
      erro_digito <= 1'b0;
      estouro     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        shift_q <= {centenas, dezenas, unidades, 10'b0};
        err_q   <= (centenas > 4'd9) || (dezenas > 4'd9) || (unidades > 4'd9);
        count_q <= '0;
      end else if (busy) begin
        shift_q <= shift_step;
        count_q <= count_q + 4'd1;
        if (last_step) begin
          done <= 1'b1;
          if (err_q) begin
            binary      <= 8'h00;
            erro_digito <= 1'b1;
            estouro     <= 1'b0;
          end else if (result > 10'd255) begin
            binary      <= 8'hFF;
            erro_digito <= 1'b0;
            estouro     <= 1'b1;
          end else begin
            binary      <= result[7:0];
            erro_digito <= 1'b0;
            estouro     <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Bench for bcd2bin_seq: arithmetic reference model feeding an expected queue,
// with a negedge monitor comparing every cycle's outputs against it.
module tb_bcd2bin_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] centenas;
  logic [3:0] dezenas;
  logic [3:0] unidades;
  logic [7:0] binary;
  logic       busy;
  logic       done;
  logic       erro_digito;
  logic       estouro;

  bcd2bin_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .centenas    (centenas),
    .dezenas     (dezenas),
    .unidades    (unidades),
    .binary      (binary),
    .busy        (busy),
    .done        (done),
    .erro_digito (erro_digito),
    .estouro     (estouro)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];   // {binary, erro_digito, estouro}
  int         due_q[$];   // cycle on which the matching done is expected
  int         cyc = 0;
  int         rem = 0;    // model: cycles left in the current conversion
  bit         rst_edge = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] held_bin = '0;
  logic       held_err = 1'b0;
  logic       held_ovf = 1'b0;

  function automatic logic [9:0] ref_val(input logic [3:0] c, input logic [3:0] d,
                                         input logic [3:0] u);
    int v;
    if (c > 9 || d > 9 || u > 9) return {8'h00, 1'b1, 1'b0};
    v = 100 * c + 10 * d + u;
    if (v > 255) return {8'hFF, 1'b0, 1'b1};
    return {v[7:0], 1'b0, 1'b0};
  endfunction

  // Reference model: decides acceptance and records the expected result
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      if (rem != 0) begin
        void'(exp_q.pop_back());
        void'(due_q.pop_back());
      end
      rem      = 0;
      rst_edge = 1'b1;
    end else begin
      rst_edge = 1'b0;
      if (rem == 0) begin
        if (start) begin
          exp_q.push_back(ref_val(centenas, dezenas, unidades));
          due_q.push_back(cyc + 10);
          rem = 10;
        end
      end else begin
        rem--;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares outputs every cycle, pops on expected done
  always @(negedge clk) begin
    logic [9:0] e;
    logic       exp_done;
    if (cyc > 0) begin
      if (rst_edge) begin
        held_bin = '0;
        held_err = 1'b0;
        held_ovf = 1'b0;
      end
      exp_done = !rst_edge && (due_q.size() > 0) && (due_q[0] == cyc);
      if (exp_done) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        held_bin = e[9:2];
        held_err = e[1];
        held_ovf = e[0];
      end
      check("done", {7'b0, done}, {7'b0, exp_done});
      check("busy", {7'b0, busy}, {7'b0, rem != 0});
      check("binary", binary, held_bin);
      check("erro_digito", {7'b0, erro_digito}, {7'b0, held_err});
      check("estouro", {7'b0, estouro}, {7'b0, held_ovf});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_digits(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
    centenas = c;
    dezenas  = d;
    unidades = u;
  endtask

  task automatic rand_digits();
    set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rem != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rem != 0) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
    end
  endtask

  // Single conversion; inputs are scrambled while it runs
  task automatic run_conv(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
    wait_idle();
    set_digits(c, d, u);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) begin
      rand_digits();
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // value sweep, overflow, invalid digits
    run_conv(4'd0, 4'd0, 4'd0);
    run_conv(4'd1, 4'd2, 4'd8);
    run_conv(4'd2, 4'd5, 4'd5);
    run_conv(4'd2, 4'd5, 4'd6);
    run_conv(4'd9, 4'd9, 4'd9);
    run_conv(4'd0, 4'hA, 4'd3);
    run_conv(4'hF, 4'd0, 4'd0);

    // reset on the step-5 edge discards the conversion
    wait_idle();
    set_digits(4'd9, 4'd9, 4'd9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_conv(4'd1, 4'd2, 4'd8);

    // start while busy is ignored
    wait_idle();
    set_digits(4'd1, 4'd2, 4'd8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    set_digits(4'd2, 4'd0, 4'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // random single conversions, including invalid digits
    for (int i = 0; i < 30; i++) begin
      run_conv(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)));
    end

    // start held high with digits changing every cycle
    wait_idle();
    start = 1'b1;
    repeat (60) begin
      set_digits(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)));
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // all valid digit combinations, back to back
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      for (int d = 0; d < 10; d++) begin
        for (int u = 0; u < 10; u++) begin
          wait_idle();
          set_digits(4'(c), 4'(d), 4'(u));
          @(negedge clk);
        end
      end
    end
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
